// File: rtl/cache_ctrl_2.sv
// Direct-mapped write-back/write-allocate controller for one 8-line way: hit resp 3 cycles after accept, misses add memory time.
// One request in flight (req_rdy only in IDLE); all handshakes hold until accepted. CACHE_CTRL_STATS_EN adds hit/miss/evict counters.
module cache_ctrl_2 #(
    parameter int p_nlines = 8,
    parameter int p_lbytes = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     req_val_i,
    output logic                     req_rdy_o,
    input  logic                     req_type_i,
    input  logic [31:0]              req_addr_i,
    input  logic [31:0]              req_data_i,
    output logic                     resp_val_o,
    input  logic                     resp_rdy_i,
    output logic [31:0]              resp_data_o,
    output logic                     mem_req_val_o,
    input  logic                     mem_req_rdy_i,
    output logic                     mem_req_type_o,
    output logic [31:0]              mem_req_addr_o,
    output logic [8*p_lbytes-1:0]    mem_req_data_o,
    input  logic                     mem_resp_val_i,
    output logic                     mem_resp_rdy_o,
    input  logic [8*p_lbytes-1:0]    mem_resp_data_i,
    output logic                     tag_read_en_o,
    output logic                     tag_write_en_o,
    output logic                     data_read_en_o,
    output logic                     data_write_en_o,
    output logic [$clog2(p_nlines)-1:0] addr_o,
    output logic [31:0]              tag_write_data_o,
    input  logic [31:0]              tag_read_data_i,
    output logic [p_lbytes-1:0]      data_write_byte_en_o,
    output logic [8*p_lbytes-1:0]    data_write_data_o,
    input  logic [8*p_lbytes-1:0]    data_read_data_i,
    input  logic                     tag_match_i
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]              stat_hits_o,
    output logic [31:0]              stat_misses_o,
    output logic [31:0]              stat_evicts_o
`endif
);

    localparam int IDX_W  = $clog2(p_nlines);
    localparam int OFF_W  = $clog2(p_lbytes);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int LINE_W = 8 * p_lbytes;
    localparam int WSEL_W = OFF_W - 2;

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_TAG_CHECK,
        S_EVICT_REQ,
        S_EVICT_WAIT,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   init_cnt_q, init_cnt_d;
    logic               req_type_q, req_type_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic [31:0]        req_data_q, req_data_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic [TAG_W-1:0]   old_tag_q, old_tag_d;

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [WSEL_W-1:0]  req_word;
    logic               line_valid;
    logic               line_dirty;
    logic               line_hit;
    logic               hit_evt;
    logic               miss_evt;
    logic               evict_evt;

    assign req_tag    = req_addr_q[31 -: TAG_W];
    assign req_idx    = req_addr_q[OFF_W +: IDX_W];
    assign req_word   = req_addr_q[2 +: WSEL_W];
    assign line_valid = tag_read_data_i[31];
    assign line_dirty = tag_read_data_i[30];
    assign line_hit   = line_valid && (tag_read_data_i[TAG_W-1:0] == req_tag);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            req_type_q  <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            resp_data_q <= '0;
            old_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            req_type_q  <= req_type_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            resp_data_q <= resp_data_d;
            old_tag_q   <= old_tag_d;
        end
    end

    // Outputs are forced idle while reset is held so no SRAM/memory traffic leaks out.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        req_type_d  = req_type_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        resp_data_d = resp_data_q;
        old_tag_d   = old_tag_q;
        hit_evt     = 1'b0;
        miss_evt    = 1'b0;
        evict_evt   = 1'b0;

        req_rdy_o            = 1'b0;
        resp_val_o           = 1'b0;
        resp_data_o          = '0;
        mem_req_val_o        = 1'b0;
        mem_req_type_o       = 1'b0;
        mem_req_addr_o       = '0;
        mem_req_data_o       = '0;
        mem_resp_rdy_o       = 1'b0;
        tag_read_en_o        = 1'b0;
        tag_write_en_o       = 1'b0;
        data_read_en_o       = 1'b0;
        data_write_en_o      = 1'b0;
        addr_o               = '0;
        tag_write_data_o     = '0;
        data_write_byte_en_o = '0;
        data_write_data_o    = '0;

        if (!reset_i) begin
            resp_data_o = resp_data_q;
            case (state_q)
                S_INIT: begin
                    tag_write_en_o = 1'b1;
                    addr_o         = init_cnt_q;
                    init_cnt_d     = init_cnt_q + 1'b1;
                    if (init_cnt_q == IDX_W'(p_nlines - 1)) begin
                        state_d = S_IDLE;
                    end
                end
                S_IDLE: begin
                    req_rdy_o = 1'b1;
                    if (req_val_i) begin
                        req_type_d = req_type_i;
                        req_addr_d = req_addr_i;
                        req_data_d = req_data_i;
                        state_d    = S_TAG_CHECK;
                    end
                end
                S_TAG_CHECK: begin
                    tag_read_en_o = 1'b1;
                    addr_o        = req_idx;
                    old_tag_d     = tag_read_data_i[TAG_W-1:0];
                    if (line_hit) begin
                        hit_evt = 1'b1;
                        state_d = S_ACCESS;
                    end else begin
                        miss_evt = 1'b1;
                        state_d  = line_dirty ? S_EVICT_REQ : S_REFILL_REQ;
                    end
                end
                S_EVICT_REQ: begin
                    // Victim line comes straight off the combinational data read; index is stable here.
                    data_read_en_o = 1'b1;
                    addr_o         = req_idx;
                    mem_req_val_o  = 1'b1;
                    mem_req_type_o = 1'b1;
                    mem_req_addr_o = {old_tag_q, req_idx, {OFF_W{1'b0}}};
                    mem_req_data_o = data_read_data_i;
                    if (mem_req_rdy_i) begin
                        evict_evt = 1'b1;
                        state_d   = S_EVICT_WAIT;
                    end
                end
                S_EVICT_WAIT: begin
                    addr_o         = req_idx;
                    mem_resp_rdy_o = 1'b1;
                    if (mem_resp_val_i) begin
                        state_d = S_REFILL_REQ;
                    end
                end
                S_REFILL_REQ: begin
                    addr_o         = req_idx;
                    mem_req_val_o  = 1'b1;
                    mem_req_type_o = 1'b0;
                    mem_req_addr_o = {req_tag, req_idx, {OFF_W{1'b0}}};
                    if (mem_req_rdy_i) begin
                        state_d = S_REFILL_WAIT;
                    end
                end
                S_REFILL_WAIT: begin
                    addr_o         = req_idx;
                    mem_resp_rdy_o = 1'b1;
                    if (mem_resp_val_i) begin
                        data_write_en_o      = 1'b1;
                        data_write_byte_en_o = '1;
                        data_write_data_o    = mem_resp_data_i;
                        tag_write_en_o       = 1'b1;
                        tag_write_data_o     = {1'b1, 1'b0, {(30 - TAG_W){1'b0}}, req_tag};
                        state_d              = S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    addr_o = req_idx;
                    if (req_type_q) begin
                        data_write_en_o      = 1'b1;
                        data_write_byte_en_o = {{(p_lbytes - 4){1'b0}}, 4'hF} << {req_word, 2'b00};
                        data_write_data_o    = {(p_lbytes / 4){req_data_q}};
                        tag_write_en_o       = 1'b1;
                        tag_write_data_o     = {1'b1, 1'b1, {(30 - TAG_W){1'b0}}, req_tag};
                        resp_data_d          = '0;
                    end else begin
                        data_read_en_o = 1'b1;
                        resp_data_d    = data_read_data_i[{req_word, 5'b00000} +: 32];
                    end
                    state_d = S_RESP;
                end
                S_RESP: begin
                    resp_val_o = 1'b1;
                    if (resp_rdy_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_INIT;
                end
            endcase
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hits_q, hits_d;
    logic [31:0] misses_q, misses_d;
    logic [31:0] evicts_q, evicts_d;

    assign hits_d   = hits_q + {31'b0, hit_evt};
    assign misses_d = misses_q + {31'b0, miss_evt};
    assign evicts_d = evicts_q + {31'b0, evict_evt};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hits_q   <= '0;
            misses_q <= '0;
            evicts_q <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
            evicts_q <= evicts_d;
        end
    end

    assign stat_hits_o   = hits_q;
    assign stat_misses_o = misses_q;
    assign stat_evicts_o = evicts_q;

    logic unused_ok;
    assign unused_ok = ^{tag_match_i, req_addr_q[1:0], tag_read_data_i[29:TAG_W]};
`else
    // The comparator output is observed only; hit is computed from the tag read data.
    logic unused_ok;
    assign unused_ok = ^{tag_match_i, req_addr_q[1:0], tag_read_data_i[29:TAG_W],
                         hit_evt, miss_evt, evict_evt};
`endif

endmodule
